load_store_unit: RTL
====================

# load_store_unit

Memory-access initiator sitting between the execute stage and the byte-addressable data memory. It accepts one load/store request at a time over a valid/ready handshake and drives the memory's `mem_read`/`mem_write`/`funct3`/`address`/`write_data` port. It returns load data or store completion over a valid/ready response channel. Misaligned halfword/word accesses are split into sequential byte beats and reassembled, so the memory only ever sees naturally aligned traffic.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request (1 only in IDLE)
- `req_is_store`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I load/store funct3
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data (low bytes used for SB/SH)
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  consumer accepts response
- `resp_rdata`  out  32  extended load data; 0 for stores and errors
- `resp_err`  out  1  illegal funct3 or unsupported misalignment
- `mem_read`  out  1  memory load enable
- `mem_write`  out  1  memory store enable
- `mem_funct3`  out  3  funct3 presented to memory
- `mem_address`  out  32  beat address
- `mem_write_data`  out  32  beat store data
- `mem_read_data`  in  32  combinational memory read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch the request and compute the beat count.
  - Legal and aligned: ACCESS with 1 beat.
  - Legal and misaligned: ACCESS with 2 (H) or 4 (W) beats.
  - Illegal: RESP with `resp_err`=1.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is illegal; no memory access is made.
- Misalignment rules:
  - Halfword is misaligned when `addr[0]`=1.
  - Word is misaligned when `addr[1:0]`≠0.
  - Bytes are never misaligned.
- Aligned beat:
  - `mem_funct3` = `req_funct3`, `mem_address` = `req_addr`, `mem_write_data` = `req_wdata`.
  - Load: `resp_rdata` = `mem_read_data` captured as-is. The memory performs the extension.
- Misaligned beat i (i = 0..N-1):
  - `mem_address` = `req_addr`+i, 32-bit modulo 2^32.
  - Load: `mem_funct3` = 100 (LBU); byte `mem_read_data[7:0]` is captured into assembly byte i, little-endian.
  - Store: `mem_funct3` = 000 (SB); `mem_write_data[7:0]` = `req_wdata` byte i.
- Misaligned load final extension:
  - LH: sign-extend from assembled bit 15.
  - LHU: zero-extend.
  - LW: no extension.
- ACCESS: after the last beat, go to RESP.
- RESP: `resp_valid`=1 with `resp_rdata`/`resp_err` held stable until `resp_ready`; then return to IDLE.
- A store response has `resp_rdata`=0 and `resp_err`=0.
- No rollback: a misaligned store interrupted by reset leaves its already-written bytes in memory.

## Timing
- Reset values (asynchronous, immediate):
  - State = IDLE.
  - `resp_valid`, `resp_rdata`, `resp_err` = 0.
  - `mem_read`, `mem_write`, `mem_funct3`, `mem_address`, `mem_write_data` = 0.
  - `req_ready` is decoded from state and reads 1, but requests are ignored while `rst`=1.
- Memory port outputs are registered.
  - `mem_read`/`mem_write` are high only during ACCESS cycles, one cycle per beat.
  - All memory outputs are 0 outside ACCESS.
- Accept at edge E0.
  - Beat i occupies the cycle after edge E0+i.
  - Load data is captured at edge E0+i+1; memory commits stores at the same edge.
- `resp_valid` rises after edge E0+N+1. Latency is N+1 edges (aligned: 2; misaligned H: 3; misaligned W: 5).
- Illegal request: `resp_valid` rises after E0+1.
- Back-to-back throughput: a new request is accepted no earlier than the edge after the response handshake, since `req_ready` is 1 only in IDLE.
- Reset during ACCESS drops `mem_write` in the same cycle, so the in-flight beat is not committed.

## Configuration
- Macro: `LSU_MISALIGN_SPLIT_EN`.
- Defined: misaligned H/W accesses are split into byte beats as described above.
- Undefined:
  - A misaligned legal request goes directly to RESP with `resp_err`=1 and `resp_rdata`=0. No memory access; latency 1 edge.
  - The byte-beat datapath is not compiled.

## Test plan
- Aligned SW 0xDEADBEEF @0x100, then LW @0x100 -> one `mem_write` cycle with funct3 010, then `resp_rdata`=0xDEADBEEF, `resp_err`=0, `resp_valid` 2 edges after accept.
- Bytes 0x101..0x104 = 11,22,33,44; LW @0x101 (macro on) -> 4 beats, funct3 100, addresses 0x101..0x104, `resp_rdata`=0x44332211, latency 5. Macro off -> no `mem_read`, `resp_err`=1.
- Bytes 0x203=0x34, 0x204=0x92:
  - LH @0x203 -> 0xFFFF9234.
  - LHU @0x203 -> 0x00009234.
  - SH 0xABCD @0x203 -> bytes become CD, AB.
- Load with funct3 011, and store with funct3 100 -> no `mem_read`/`mem_write`, `resp_err`=1, `resp_rdata`=0, `resp_valid` after 1 edge.
- `resp_ready` held low 3 cycles after LW -> `resp_valid`, `resp_rdata`, `resp_err` stable and `req_ready`=0 throughout; a request presented meanwhile is accepted only after the response handshake.
- `rst` asserted during beat 2 of misaligned SW 0x88776655 @0x301 -> `mem_write` low immediately, state IDLE, bytes 0x301/0x302 = 55/66, bytes 0x303/0x304 unchanged.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store initiator: one request at a time, registered memory port, valid/ready response.
// Optional LSU_MISALIGN_SPLIT_EN splits misaligned H/W accesses into byte beats; otherwise they error.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  beat_q, beat_d, nbeats_q, nbeats_d;
  logic        store_q, store_d, err_q, err_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, asm_q, asm_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [2:0]  mem_funct3_q, mem_funct3_d;
  logic [31:0] mem_address_q, mem_address_d, mem_write_data_q, mem_write_data_d;
  logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic        split_q, split_d, src_split;
`endif

  logic        req_legal, req_misal, req_err, drive, src_store;
  logic [2:0]  req_nbeats, src_f3, src_idx;
  logic [31:0] src_addr, src_wdata, final_rdata;

  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !req_is_store;
      default:                req_legal = 1'b0;
    endcase
    req_misal = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_SPLIT_EN
    req_err    = !req_legal;
    req_nbeats = !req_legal ? 3'd0 : !req_misal ? 3'd1 :
                 (req_funct3[1:0] == 2'b01) ? 3'd2 : 3'd4;
`else
    req_err    = !req_legal || req_misal;
    req_nbeats = req_err ? 3'd0 : 3'd1;
`endif
  end

  always_comb begin
    final_rdata = asm_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    if (split_q) begin
      case (f3_q)
        3'b001:  final_rdata = {{16{asm_q[15]}}, asm_q[15:0]};
        3'b101:  final_rdata = {16'h0000, asm_q[15:0]};
        default: final_rdata = asm_q;
      endcase
    end
`endif
  end

  // Memory outputs are registered, so the beat presented next cycle is computed here:
  // from the incoming request while accepting, else from the latched request at beat_q+1.
  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    nbeats_d         = nbeats_q;
    store_d          = store_q;
    err_d            = err_q;
    f3_d             = f3_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    asm_d            = asm_q;
    resp_valid_d     = resp_valid_q;
    resp_err_d       = resp_err_q;
    resp_rdata_d     = resp_rdata_q;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    mem_funct3_d     = '0;
    mem_address_d    = '0;
    mem_write_data_d = '0;
    drive            = 1'b0;
    src_store        = store_q;
    src_f3           = f3_q;
    src_addr         = addr_q;
    src_wdata        = wdata_q;
    src_idx          = beat_q + 3'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d          = split_q;
    src_split        = split_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d   = ACCESS;
          beat_d    = '0;
          nbeats_d  = req_nbeats;
          store_d   = req_is_store;
          err_d     = req_err;
          f3_d      = req_funct3;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          asm_d     = '0;
          drive     = (req_nbeats != 3'd0);
          src_store = req_is_store;
          src_f3    = req_funct3;
          src_addr  = req_addr;
          src_wdata = req_wdata;
          src_idx   = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          split_d   = req_misal;
          src_split = req_misal;
`endif
        end
      end
      ACCESS: begin
        if (beat_q < nbeats_q) begin
          asm_d  = mem_read_data;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q)
            asm_d = asm_q | ({24'h000000, mem_read_data[7:0]} << {beat_q, 3'b000});
`endif
          beat_d = beat_q + 3'd1;
          drive  = (beat_q + 3'd1 < nbeats_q);
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = err_q;
          resp_rdata_d = (err_q || store_q) ? '0 : final_rdata;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (drive) begin
      mem_read_d       = !src_store;
      mem_write_d      = src_store;
      mem_funct3_d     = src_f3;
      mem_address_d    = src_addr;
      mem_write_data_d = src_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
      if (src_split) begin
        mem_funct3_d     = src_store ? 3'b000 : 3'b100;
        mem_address_d    = src_addr + {29'd0, src_idx};
        mem_write_data_d = {24'h000000, 8'(src_wdata >> {src_idx, 3'b000})};
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      beat_q           <= '0;
      nbeats_q         <= '0;
      store_q          <= 1'b0;
      err_q            <= 1'b0;
      f3_q             <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      asm_q            <= '0;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_funct3_q     <= '0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q          <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      beat_q           <= beat_d;
      nbeats_q         <= nbeats_d;
      store_q          <= store_d;
      err_q            <= err_d;
      f3_q             <= f3_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      asm_q            <= asm_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      resp_rdata_q     <= resp_rdata_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_funct3_q     <= mem_funct3_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q          <= split_d;
`endif
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_funct3     = mem_funct3_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;

endmodule
